cu_fsm_ctrl: RTL
================

// Module: cu_fsm_ctrl
// PURPOSE
//  Multicycle OTTER control unit: FSM sequencing plus full RV32I decode.
//  Sequences fetch/execute/writeback, drives the datapath mux selects and write strobes, and takes interrupts at instruction boundaries.
//  Sits between the IR/branch-condition generator and the PC, regfile, memory, ALU and CSR datapath.
// PARAMETERS
//  MEM_LAT   1  load-data latency in cycles spent in ST_WB (1..15); 1 = single WB cycle
//  INTR_EN   1  0 = intr input ignored, ST_INTR unreachable
// PORTS
//  CLK        in   1  system clock, rising edge
//  RST_N      in   1  asynchronous, active-low reset
//  opcode     in   7  ir[6:0]
//  func7      in   1  ir[30]
//  func3      in   3  ir[14:12]
//  br_eq      in   1  rs1==rs2
//  br_lt      in   1  rs1<rs2 signed
//  br_ltu     in   1  rs1<rs2 unsigned
//  intr       in   1  level interrupt request
//  mie        in   1  CSR interrupt enable
//  mem_rden1  out  1  instruction read strobe
//  mem_rden2  out  1  data read strobe
//  mem_we2    out  1  data write strobe
//  pc_write   out  1  PC load enable
//  reg_write  out  1  regfile write enable
//  csr_we     out  1  CSR write enable
//  int_taken  out  1  interrupt entry pulse (CSR saves mepc, clears mie)
//  mret_exec  out  1  MRET pulse (CSR restores mie)
//  illegal_op out  1  undefined opcode in ST_EXEC
//  alu_fun    out  4  ALU operation
//  pc_source  out  3  0 PC+4, 1 JALR, 2 branch, 3 JAL, 4 mtvec, 5 mepc
//  alu_srcA   out  1  0 rs1, 1 U-imm
//  alu_srcB   out  2  0 rs2, 1 I-imm, 2 S-imm, 3 PC
//  rf_wr_sel  out  2  0 PC+4, 1 CSR rd, 2 mem dout, 3 ALU
// BEHAVIOUR
//  Reset: RST_N low -> state ST_INIT, lat_cnt 0; all strobes 0 immediately, even mid-instruction. Selects 0 while in ST_INIT/ST_FETCH.
//  States: ST_INIT->ST_FETCH (1 cycle); ST_FETCH: mem_rden1=1 -> ST_EXEC.
//  ST_EXEC, non-LOAD: pc_write=1 -> ST_INTR if (INTR_EN && intr && mie), else ST_FETCH.
//  ST_EXEC, LOAD: mem_rden2=1, pc_write=0 -> ST_WB with lat_cnt=MEM_LAT-1.
//  ST_WB: decode held on LOAD; while lat_cnt!=0, decrement and stay, no strobes.
//    At lat_cnt==0: reg_write=1, pc_write=1, then same intr test as ST_EXEC.
//  ST_INTR: pc_write=1, pc_source=4, int_taken=1 -> ST_FETCH. Interrupt is never taken mid-instruction.
//  reg_write in ST_EXEC: LUI, AUIPC, JAL, JALR, OP_IMM, OP, CSRRW; never STORE/BRANCH. mem_we2: STORE only.
//  Decode (combinational; valid in ST_EXEC/ST_WB):
//   LUI: alu_fun=1001, srcA=1, wr_sel=3.  AUIPC: fun=0000, srcA=1, srcB=3, wr_sel=3.
//   JAL: pc_source=3, wr_sel=0.  JALR: pc_source=1, wr_sel=0.
//   LOAD: fun=0000, srcB=1, wr_sel=2.  STORE: fun=0000, srcB=2.
//   OP: fun={func7,func3}, srcB=0, wr_sel=3.
//   OP_IMM: fun={func7&(func3==101),func3}, srcB=1, wr_sel=3.
//   BRANCH: pc_source=2 when taken else 0.
//     BEQ eq, BNE !eq, BLT lt, BGE !lt, BLTU ltu, BGEU !ltu; func3 010/011 never taken.
//   SYSTEM (1110011):
//     func3=001 CSRRW: csr_we=1, reg_write=1, wr_sel=1.
//     func3=000 MRET: pc_source=5, mret_exec=1.
//     Other func3: no writes, pc_write=1.
//   Undefined opcode: illegal_op=1, pc_write=1 only (skip instruction), selects 0.
//  intr and a concurrent MRET: MRET completes (pc<-mepc), then ST_INTR if mie is already restored.
// STRUCTURE
//  Package otter_cu_pkg: opcode_t, br_func3_t, cu_state_t, PC_SRC_*/WR_SEL_*/SRCB_* constants.
//  Sub-module cu_dcdr_rv32i: pure combinational decode (selects, branch taken, write-class flags).
//  Top: state register, lat_cnt, strobe generation gated by state.
// TESTING
//  ADDI (0010011,f3=000) after reset: INIT,FETCH,EXEC -> srcB=1, wr_sel=3, reg_write&pc_write in EXEC only.
//  LW, MEM_LAT=3: rden2 in EXEC; WB 3 cycles; reg_write+pc_write only on 3rd WB cycle, wr_sel=2.
//  BGE with br_lt=0 -> pc_source=2; br_lt=1 -> 0; f3=010 -> 0; reg_write=0 throughout.
//  intr=1, mie=1 during ADD EXEC -> next state ST_INTR: int_taken=1, pc_source=4; mie=0 -> FETCH.
//  RST_N low mid-WB of a load -> strobes drop at once; after release, INIT then FETCH.
//  Opcode 0000000 -> illegal_op=1, pc_write=1, reg_write=0, mem_we2=0; CSRRW -> csr_we=1, wr_sel=1.

Source files
------------

// File: rtl/otter_cu_pkg.sv
// Shared types and select encodings for the OTTER multicycle control unit.
package otter_cu_pkg;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_SYSTEM = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_func3_t;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_FETCH,
    ST_EXEC,
    ST_WB,
    ST_INTR
  } cu_state_t;

  localparam logic [2:0] PC_SRC_PC4    = 3'd0;
  localparam logic [2:0] PC_SRC_JALR   = 3'd1;
  localparam logic [2:0] PC_SRC_BRANCH = 3'd2;
  localparam logic [2:0] PC_SRC_JAL    = 3'd3;
  localparam logic [2:0] PC_SRC_MTVEC  = 3'd4;
  localparam logic [2:0] PC_SRC_MEPC   = 3'd5;

  localparam logic [1:0] WR_SEL_PC4 = 2'd0;
  localparam logic [1:0] WR_SEL_CSR = 2'd1;
  localparam logic [1:0] WR_SEL_MEM = 2'd2;
  localparam logic [1:0] WR_SEL_ALU = 2'd3;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IIMM = 2'd1;
  localparam logic [1:0] SRCB_SIMM = 2'd2;
  localparam logic [1:0] SRCB_PC   = 2'd3;

  localparam logic [2:0] F3_MRET  = 3'b000;
  localparam logic [2:0] F3_CSRRW = 3'b001;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_LUI = 4'b1001;

endpackage

// File: rtl/cu_dcdr_rv32i.sv
// Pure combinational RV32I decode: datapath selects, branch resolution and
// write-class flags. The FSM decides when any of these may take effect.
module cu_dcdr_rv32i
  import otter_cu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic       func7,
  input  logic [2:0] func3,
  input  logic       br_eq,
  input  logic       br_lt,
  input  logic       br_ltu,
  output logic [3:0] alu_fun,
  output logic       alu_srcA,
  output logic [1:0] alu_srcB,
  output logic [1:0] rf_wr_sel,
  output logic [2:0] pc_source,
  output logic       is_load,
  output logic       rf_wr,
  output logic       mem_wr,
  output logic       csr_wr,
  output logic       is_mret,
  output logic       illegal
);

  logic br_taken;

  always_comb begin
    br_taken = 1'b0;
    case (func3)
      BR_BEQ:  br_taken = br_eq;
      BR_BNE:  br_taken = !br_eq;
      BR_BLT:  br_taken = br_lt;
      BR_BGE:  br_taken = !br_lt;
      BR_BLTU: br_taken = br_ltu;
      BR_BGEU: br_taken = !br_ltu;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    alu_fun   = ALU_ADD;
    alu_srcA  = 1'b0;
    alu_srcB  = SRCB_RS2;
    rf_wr_sel = WR_SEL_PC4;
    pc_source = PC_SRC_PC4;
    is_load   = 1'b0;
    rf_wr     = 1'b0;
    mem_wr    = 1'b0;
    csr_wr    = 1'b0;
    is_mret   = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OPC_LUI: begin
        alu_fun   = ALU_LUI;
        alu_srcA  = 1'b1;
        rf_wr_sel = WR_SEL_ALU;
        rf_wr     = 1'b1;
      end
      OPC_AUIPC: begin
        alu_srcA  = 1'b1;
        alu_srcB  = SRCB_PC;
        rf_wr_sel = WR_SEL_ALU;
        rf_wr     = 1'b1;
      end
      OPC_JAL: begin
        pc_source = PC_SRC_JAL;
        rf_wr     = 1'b1;
      end
      OPC_JALR: begin
        pc_source = PC_SRC_JALR;
        rf_wr     = 1'b1;
      end
      OPC_LOAD: begin
        alu_srcB  = SRCB_IIMM;
        rf_wr_sel = WR_SEL_MEM;
        is_load   = 1'b1;
      end
      OPC_STORE: begin
        alu_srcB = SRCB_SIMM;
        mem_wr   = 1'b1;
      end
      OPC_OP: begin
        alu_fun   = {func7, func3};
        rf_wr_sel = WR_SEL_ALU;
        rf_wr     = 1'b1;
      end
      OPC_OP_IMM: begin
        // bit30 is immediate data except for SRAI
        alu_fun   = {func7 & (func3 == 3'b101), func3};
        alu_srcB  = SRCB_IIMM;
        rf_wr_sel = WR_SEL_ALU;
        rf_wr     = 1'b1;
      end
      OPC_BRANCH: begin
        pc_source = br_taken ? PC_SRC_BRANCH : PC_SRC_PC4;
      end
      OPC_SYSTEM: begin
        if (func3 == F3_CSRRW) begin
          rf_wr_sel = WR_SEL_CSR;
          rf_wr     = 1'b1;
          csr_wr    = 1'b1;
        end else if (func3 == F3_MRET) begin
          pc_source = PC_SRC_MEPC;
          is_mret   = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cu_fsm_ctrl.sv
// Multicycle OTTER control unit: fetch/execute/writeback sequencing, strobe
// gating by state and interrupt entry at instruction boundaries.
//  state    | meaning
//  ST_INIT  | one idle cycle after reset
//  ST_FETCH | instruction read
//  ST_EXEC  | execute; non-loads retire here
//  ST_WB    | load data wait (lat_cnt) then register writeback
//  ST_INTR  | interrupt entry, PC <- mtvec
module cu_fsm_ctrl
  import otter_cu_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter bit INTR_EN = 1'b1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [6:0] opcode,
  input  logic       func7,
  input  logic [2:0] func3,
  input  logic       br_eq,
  input  logic       br_lt,
  input  logic       br_ltu,
  input  logic       intr,
  input  logic       mie,
  output logic       mem_rden1,
  output logic       mem_rden2,
  output logic       mem_we2,
  output logic       pc_write,
  output logic       reg_write,
  output logic       csr_we,
  output logic       int_taken,
  output logic       mret_exec,
  output logic       illegal_op,
  output logic [3:0] alu_fun,
  output logic [2:0] pc_source,
  output logic       alu_srcA,
  output logic [1:0] alu_srcB,
  output logic [1:0] rf_wr_sel
);

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

  cu_state_t  state;
  logic [3:0] lat_cnt;
  logic       take_intr;

  logic [3:0] dec_alu_fun;
  logic       dec_src_a;
  logic [1:0] dec_src_b;
  logic [1:0] dec_wr_sel;
  logic [2:0] dec_pc_src;
  logic       dec_load, dec_rf_wr, dec_mem_wr, dec_csr_wr, dec_mret, dec_illegal;

  cu_dcdr_rv32i u_dcdr (
    .opcode    (opcode),
    .func7     (func7),
    .func3     (func3),
    .br_eq     (br_eq),
    .br_lt     (br_lt),
    .br_ltu    (br_ltu),
    .alu_fun   (dec_alu_fun),
    .alu_srcA  (dec_src_a),
    .alu_srcB  (dec_src_b),
    .rf_wr_sel (dec_wr_sel),
    .pc_source (dec_pc_src),
    .is_load   (dec_load),
    .rf_wr     (dec_rf_wr),
    .mem_wr    (dec_mem_wr),
    .csr_wr    (dec_csr_wr),
    .is_mret   (dec_mret),
    .illegal   (dec_illegal)
  );

  assign take_intr = INTR_EN && intr && mie;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= ST_INIT;
      lat_cnt <= '0;
    end else begin
      case (state)
        ST_INIT:  state <= ST_FETCH;
        ST_FETCH: state <= ST_EXEC;
        ST_EXEC: begin
          if (dec_load) begin
            state   <= ST_WB;
            lat_cnt <= LAT_INIT;
          end else begin
            state <= take_intr ? ST_INTR : ST_FETCH;
          end
        end
        ST_WB: begin
          if (lat_cnt != 4'd0) lat_cnt <= lat_cnt - 4'd1;
          else state <= take_intr ? ST_INTR : ST_FETCH;
        end
        ST_INTR:  state <= ST_FETCH;
        default:  state <= ST_INIT;
      endcase
    end
  end

  // Strobes are decoded from the state register so reset kills them at once
  always_comb begin
    mem_rden1  = 1'b0;
    mem_rden2  = 1'b0;
    mem_we2    = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    csr_we     = 1'b0;
    int_taken  = 1'b0;
    mret_exec  = 1'b0;
    illegal_op = 1'b0;
    alu_fun    = '0;
    pc_source  = PC_SRC_PC4;
    alu_srcA   = 1'b0;
    alu_srcB   = SRCB_RS2;
    rf_wr_sel  = WR_SEL_PC4;
    case (state)
      ST_FETCH: mem_rden1 = 1'b1;
      ST_EXEC: begin
        alu_fun   = dec_alu_fun;
        pc_source = dec_pc_src;
        alu_srcA  = dec_src_a;
        alu_srcB  = dec_src_b;
        rf_wr_sel = dec_wr_sel;
        if (dec_load) begin
          mem_rden2 = 1'b1;
        end else begin
          pc_write   = 1'b1;
          reg_write  = dec_rf_wr;
          mem_we2    = dec_mem_wr;
          csr_we     = dec_csr_wr;
          mret_exec  = dec_mret;
          illegal_op = dec_illegal;
        end
      end
      ST_WB: begin
        alu_fun   = dec_alu_fun;
        pc_source = dec_pc_src;
        alu_srcA  = dec_src_a;
        alu_srcB  = dec_src_b;
        rf_wr_sel = dec_wr_sel;
        if (lat_cnt == 4'd0) begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
        end
      end
      ST_INTR: begin
        pc_write  = 1'b1;
        pc_source = PC_SRC_MTVEC;
        int_taken = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
